// File: rtl/ata_pio_device_if.sv
// IDE host/device strobe, select and address bundle. The 16-bit DD data bus is
// tri-stated, so it stays a plain inout port on the device.
interface ata_pio_device_if;
    logic [1:0] CS_n;
    logic [2:0] DA;
    logic       IOR_n;
    logic       IOW_n;
    logic       INTRQ;

    modport master (output CS_n, DA, IOR_n, IOW_n, input INTRQ);
    modport slave  (input CS_n, DA, IOR_n, IOW_n, output INTRQ);
endinterface

// File: rtl/ata_pio_device.sv
// Device-side ATA PIO responder: task file, 256x16 sector buffer and
// READ SECTORS / WRITE SECTORS sequencing with BSY/DRQ/INTRQ handshakes.
module ata_pio_device #(
    parameter int BUSY_CYCLES = 16,
    parameter int DEVICE_ID   = 0
) (
    input  logic            CLK,
    input  logic            RESET_n,
    ata_pio_device_if.slave bus,
    inout  wire  [15:0]     DD
);
    typedef enum logic [2:0] {IDLE, BUSY, DRQ_RD, DRQ_WR, SRST} state_t;
    typedef enum logic [1:0] {P_RD, P_WR, P_IDLE, P_QUIET} pend_t;

    localparam logic [15:0] BUSY_LOAD = 16'(BUSY_CYCLES - 32'sd1);
    localparam logic        DEV_BIT   = (DEVICE_ID != 32'sd0);

    state_t      state_r, state_next;
    pend_t       pend_r, pend_next;
    logic [2:0]  ior_sync_r, iow_sync_r;
    logic [15:0] wr_data_r;
    logic [2:0]  wr_da_r, rd_da_r;
    logic [1:0]  wr_cs_r, rd_cs_r;
    logic [7:0]  error_r, seccount_r, device_r, ptr_r;
    logic [23:0] lba_r;
    logic        nien_r, srst_r, err_flag_r, irq_r;
    logic [15:0] cnt_r;
    logic [15:0] buffer [256];
    logic [15:0] data_word_r, rd_data_r;
    logic [7:0]  status_s, sec_dec_s;
    logic        ior_rise_s, iow_rise_s, matched_s, bsy_s, sel_s, tf_wr_s;
    logic        cmd_accept_s, data_wr_s, data_rd_s, status_rd_s;
    logic        set_irq_s, abort_s, sector_adv_s;

    // Strobe edge detection and host access decode
    always_comb begin
        ior_rise_s   = ior_sync_r[1] & ~ior_sync_r[2];
        iow_rise_s   = iow_sync_r[1] & ~iow_sync_r[2];
        matched_s    = (device_r[4] == DEV_BIT);
        bsy_s        = (state_r == BUSY) || (state_r == SRST);
        sel_s        = (bus.CS_n == 2'b10) || (bus.CS_n == 2'b01);
        sec_dec_s    = seccount_r - 8'd1;
        tf_wr_s      = iow_rise_s && (wr_cs_r == 2'b10) && !bsy_s;
        cmd_accept_s = tf_wr_s && (wr_da_r == 3'd7) && matched_s && !srst_r;
        data_wr_s    = tf_wr_s && (wr_da_r == 3'd0) && matched_s && (state_r == DRQ_WR);
        data_rd_s    = ior_rise_s && (rd_cs_r == 2'b10) && (rd_da_r == 3'd0) && matched_s && (state_r == DRQ_RD);
        status_rd_s  = ior_rise_s && (rd_cs_r == 2'b10) && (rd_da_r == 3'd7) && matched_s;
        case (state_r)
            BUSY, SRST:     status_s = 8'h80;
            DRQ_RD, DRQ_WR: status_s = 8'h58;
            default:        status_s = {7'b0101_000, err_flag_r};
        endcase
    end

    // Command sequencing next-state logic
    always_comb begin
        state_next   = state_r;
        pend_next    = pend_r;
        set_irq_s    = 1'b0;
        abort_s      = 1'b0;
        sector_adv_s = 1'b0;
        if (srst_r) begin
            state_next = SRST;
        end else begin
            case (state_r)
                IDLE, DRQ_RD, DRQ_WR: begin
                    if (cmd_accept_s) begin
                        case (wr_data_r[7:0])
                            8'h20: begin
                                state_next = BUSY;
                                pend_next  = P_RD;
                            end
                            8'h30:   state_next = DRQ_WR;
                            default: begin
                                state_next = IDLE;
                                abort_s    = 1'b1;
                                set_irq_s  = 1'b1;
                            end
                        endcase
                    end else if (data_rd_s && (ptr_r == 8'hFF)) begin
                        sector_adv_s = 1'b1;
                        state_next   = (sec_dec_s == 8'h00) ? IDLE : BUSY;
                        pend_next    = P_RD;
                    end else if (data_wr_s && (ptr_r == 8'hFF)) begin
                        sector_adv_s = 1'b1;
                        state_next   = BUSY;
                        pend_next    = (sec_dec_s == 8'h00) ? P_IDLE : P_WR;
                    end else begin
                        state_next = state_r;
                    end
                end
                BUSY: begin
                    if (cnt_r == 16'd0) begin
                        case (pend_r)
                            P_RD:    begin state_next = DRQ_RD; set_irq_s = 1'b1; end
                            P_WR:    begin state_next = DRQ_WR; set_irq_s = 1'b1; end
                            P_IDLE:  begin state_next = IDLE;   set_irq_s = 1'b1; end
                            default: state_next = IDLE;
                        endcase
                    end else begin
                        state_next = BUSY;
                    end
                end
                SRST: begin
                    state_next = BUSY;
                    pend_next  = P_QUIET;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State register and BSY dwell counter
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_r <= IDLE;
            pend_r  <= P_QUIET;
            cnt_r   <= 16'd0;
        end else begin
            state_r <= state_next;
            pend_r  <= pend_next;
            if ((state_next == BUSY) && (state_r != BUSY)) begin
                cnt_r <= BUSY_LOAD;
            end else if (cnt_r != 16'd0) begin
                cnt_r <= cnt_r - 16'd1;
            end
        end
    end

    // Strobe synchronisers; write/read addressing captured while the strobe is low
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            ior_sync_r <= 3'b111;
            iow_sync_r <= 3'b111;
            wr_data_r  <= 16'h0000;
            wr_da_r    <= 3'd0;
            wr_cs_r    <= 2'b11;
            rd_da_r    <= 3'd0;
            rd_cs_r    <= 2'b11;
        end else begin
            ior_sync_r <= {ior_sync_r[1:0], bus.IOR_n};
            iow_sync_r <= {iow_sync_r[1:0], bus.IOW_n};
            if (!iow_sync_r[1]) begin
                wr_data_r <= DD;
                wr_da_r   <= bus.DA;
                wr_cs_r   <= bus.CS_n;
            end
            if (!ior_sync_r[1]) begin
                rd_da_r <= bus.DA;
                rd_cs_r <= bus.CS_n;
            end
        end
    end

    // Task file, buffer pointer and interrupt bookkeeping; Features has no
    // effect on the supported commands, so it is not stored
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            error_r    <= 8'h01;
            seccount_r <= 8'h01;
            lba_r      <= 24'h000001;
            device_r   <= 8'h00;
            nien_r     <= 1'b0;
            srst_r     <= 1'b0;
            err_flag_r <= 1'b0;
            irq_r      <= 1'b0;
            ptr_r      <= 8'h00;
        end else begin
            if (iow_rise_s && (wr_cs_r == 2'b01) && (wr_da_r == 3'd6)) begin
                nien_r <= wr_data_r[1];
                srst_r <= wr_data_r[2];
            end
            if (tf_wr_s) begin
                case (wr_da_r)
                    3'd2:    seccount_r     <= wr_data_r[7:0];
                    3'd3:    lba_r[7:0]     <= wr_data_r[7:0];
                    3'd4:    lba_r[15:8]    <= wr_data_r[7:0];
                    3'd5:    lba_r[23:16]   <= wr_data_r[7:0];
                    3'd6:    device_r       <= wr_data_r[7:0];
                    default: ;
                endcase
            end
            if (data_wr_s || data_rd_s) begin
                ptr_r <= ptr_r + 8'd1;
            end
            if (sector_adv_s) begin
                seccount_r <= sec_dec_s;
                lba_r      <= lba_r + 24'd1;
            end
            if (cmd_accept_s) begin
                ptr_r      <= 8'h00;
                error_r    <= 8'h00;
                err_flag_r <= 1'b0;
                irq_r      <= 1'b0;
            end
            if (abort_s) begin
                error_r    <= 8'h04;
                err_flag_r <= 1'b1;
            end
            if (status_rd_s) begin
                irq_r <= 1'b0;
            end
            if (set_irq_s) begin
                irq_r <= 1'b1;
            end
            // Soft reset holds the power-on signature until DevCtl.SRST drops
            if (state_r == SRST) begin
                error_r    <= 8'h01;
                seccount_r <= 8'h01;
                lba_r      <= 24'h000001;
                ptr_r      <= 8'h00;
                err_flag_r <= 1'b0;
                irq_r      <= 1'b0;
            end
        end
    end

    // Sector buffer with a one-cycle prefetch of the word at the pointer
    always_ff @(posedge CLK) begin
        if (data_wr_s) begin
            buffer[ptr_r] <= wr_data_r;
        end
        data_word_r <= buffer[ptr_r];
    end

    // Registered read mux; DA/CS_n are held stable by the host during a read
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            rd_data_r <= 16'h0000;
        end else begin
            case ({bus.CS_n, bus.DA})
                5'b10_000: rd_data_r <= (state_r == DRQ_RD) ? data_word_r : 16'h0000;
                5'b10_001: rd_data_r <= {8'h00, error_r};
                5'b10_010: rd_data_r <= {8'h00, seccount_r};
                5'b10_011: rd_data_r <= {8'h00, lba_r[7:0]};
                5'b10_100: rd_data_r <= {8'h00, lba_r[15:8]};
                5'b10_101: rd_data_r <= {8'h00, lba_r[23:16]};
                5'b10_110: rd_data_r <= {8'h00, device_r};
                5'b10_111: rd_data_r <= {8'h00, status_s};
                5'b01_110: rd_data_r <= {8'h00, status_s};
                default:   rd_data_r <= 16'h0000;
            endcase
        end
    end

    assign DD        = (!bus.IOR_n && sel_s && matched_s) ? rd_data_r : 16'hzzzz;
    assign bus.INTRQ = irq_r & ~nien_r;
endmodule

// File: tb/tb_ata_pio_device.sv
// Directed host-side bench for ata_pio_device: PIO register access, sector
// loopback, multi-sector LBA wrap, abort, nIEN masking, soft reset, device select.
module tb_ata_pio_device;
    localparam logic [1:0] CMD = 2'b10;
    localparam logic [1:0] CTL = 2'b01;

    logic        CLK     = 1'b0;
    logic        RESET_n = 1'b0;
    logic        host_oe = 1'b0;
    logic [15:0] host_dd = 16'h0000;
    logic [15:0] v;
    tri1  [15:0] dd;
    int          n_checks = 0;
    int          n_fail   = 0;

    ata_pio_device_if bus ();
    assign dd = host_oe ? host_dd : 16'hzzzz;

    ata_pio_device #(.BUSY_CYCLES(16), .DEVICE_ID(0)) dut (
        .CLK(CLK), .RESET_n(RESET_n), .bus(bus.slave), .DD(dd)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [1:0] cs, input logic [2:0] da, input logic [15:0] d);
        @(posedge CLK); #1;
        bus.CS_n = cs; bus.DA = da; host_dd = d; host_oe = 1'b1;
        bus.IOW_n = 1'b0;
        tick(4);
        bus.IOW_n = 1'b1;
        tick(4);
        host_oe = 1'b0; bus.CS_n = 2'b11;
    endtask

    task automatic rd(input logic [1:0] cs, input logic [2:0] da, output logic [15:0] d);
        @(posedge CLK); #1;
        bus.CS_n = cs; bus.DA = da;
        bus.IOR_n = 1'b0;
        tick(4);
        d = dd;
        bus.IOR_n = 1'b1;
        tick(4);
        bus.CS_n = 2'b11;
    endtask

    task automatic rdc(input logic [1:0] cs, input logic [2:0] da, input logic [15:0] exp, input string tag);
        logic [15:0] r;
        rd(cs, da, r);
        check(tag, r, exp);
    endtask

    task automatic chk_irq(input logic exp, input string tag);
        check(tag, {15'd0, bus.INTRQ}, {15'd0, exp});
    endtask

    initial begin
        bus.CS_n = 2'b11; bus.DA = 3'd0; bus.IOR_n = 1'b1; bus.IOW_n = 1'b1;
        tick(4);
        RESET_n = 1'b1;
        tick(2);

        // Post-reset signature and idle bus
        chk_irq(1'b0, "rst_intrq");
        check("rst_dd_hiz", dd, 16'hFFFF);
        rdc(CMD, 3'd2, 16'h0001, "rst_seccount");
        rdc(CMD, 3'd3, 16'h0001, "rst_lba0");
        rdc(CMD, 3'd4, 16'h0000, "rst_lba1");
        rdc(CMD, 3'd5, 16'h0000, "rst_lba2");
        rdc(CMD, 3'd1, 16'h0001, "rst_error");
        rdc(CMD, 3'd6, 16'h0000, "rst_device");
        rdc(CMD, 3'd7, 16'h0050, "rst_status");
        rdc(CTL, 3'd6, 16'h0050, "rst_altstatus");
        rdc(CMD, 3'd0, 16'h0000, "rst_data_outside_drq");

        // WRITE SECTORS, one sector of 0x0000..0x00FF
        wr(CMD, 3'd2, 16'h0001);
        wr(CMD, 3'd7, 16'h0030);
        chk_irq(1'b0, "wr_cmd_no_irq");
        rdc(CMD, 3'd7, 16'h0058, "wr_drq_status");
        for (int i = 0; i < 256; i++) wr(CMD, 3'd0, 16'(i));
        chk_irq(1'b0, "wr_busy_no_irq");
        rdc(CMD, 3'd7, 16'h0080, "wr_busy_status");
        tick(30);
        chk_irq(1'b1, "wr_done_irq");
        rdc(CMD, 3'd7, 16'h0050, "wr_done_status");
        chk_irq(1'b0, "wr_status_clears_irq");
        rdc(CMD, 3'd3, 16'h0002, "wr_lba0");
        rdc(CMD, 3'd2, 16'h0000, "wr_seccount");

        // READ SECTORS loopback of the same buffer
        wr(CMD, 3'd2, 16'h0001);
        wr(CMD, 3'd7, 16'h0020);
        chk_irq(1'b0, "rd_cmd_no_irq");
        rdc(CMD, 3'd7, 16'h0080, "rd_busy_status");
        tick(30);
        chk_irq(1'b1, "rd_drq_irq");
        rdc(CTL, 3'd6, 16'h0058, "rd_altstatus");
        chk_irq(1'b1, "rd_alt_keeps_irq");
        rdc(CMD, 3'd7, 16'h0058, "rd_status");
        chk_irq(1'b0, "rd_status_clears_irq");
        for (int i = 0; i < 256; i++) begin
            rd(CMD, 3'd0, v);
            check("rd_data", v, 16'(i));
        end
        rdc(CMD, 3'd7, 16'h0050, "rd_end_status");
        chk_irq(1'b0, "rd_end_no_irq");
        rdc(CMD, 3'd2, 16'h0000, "rd_end_seccount");
        rdc(CMD, 3'd3, 16'h0003, "rd_end_lba0");

        // Two-sector read across the 24-bit LBA wrap
        wr(CMD, 3'd2, 16'h0002);
        wr(CMD, 3'd3, 16'h00FF);
        wr(CMD, 3'd4, 16'h00FF);
        wr(CMD, 3'd5, 16'h00FF);
        wr(CMD, 3'd7, 16'h0020);
        for (int s = 0; s < 2; s++) begin
            tick(30);
            chk_irq(1'b1, "ms_irq");
            rdc(CMD, 3'd7, 16'h0058, "ms_drq_status");
            for (int i = 0; i < 256; i++) begin
                rd(CMD, 3'd0, v);
                if ((i == 0) || (i == 255)) check("ms_data", v, 16'(i));
            end
            rdc(CMD, 3'd7, (s == 0) ? 16'h0080 : 16'h0050, "ms_sector_end_status");
            chk_irq(1'b0, "ms_sector_end_irq");
            rdc(CMD, 3'd3, 16'(s), "ms_lba0");
        end
        rdc(CMD, 3'd4, 16'h0000, "ms_lba1");
        rdc(CMD, 3'd5, 16'h0000, "ms_lba2");
        rdc(CMD, 3'd2, 16'h0000, "ms_seccount");

        // Unsupported command abort, then nIEN masking
        wr(CMD, 3'd7, 16'h00EC);
        chk_irq(1'b1, "abort_irq");
        rdc(CMD, 3'd1, 16'h0004, "abort_error");
        rdc(CMD, 3'd7, 16'h0051, "abort_status");
        chk_irq(1'b0, "abort_irq_cleared");
        wr(CTL, 3'd6, 16'h0002);
        wr(CMD, 3'd7, 16'h00EC);
        tick(30);
        chk_irq(1'b0, "nien_masks_irq");
        rdc(CTL, 3'd6, 16'h0051, "nien_altstatus");
        wr(CTL, 3'd6, 16'h0000);
        chk_irq(1'b1, "nien_release_irq");
        rdc(CMD, 3'd7, 16'h0051, "nien_status");

        // Soft reset in the middle of a read
        wr(CMD, 3'd2, 16'h0005);
        wr(CMD, 3'd3, 16'h0033);
        wr(CMD, 3'd4, 16'h0044);
        wr(CMD, 3'd7, 16'h0020);
        tick(30);
        chk_irq(1'b1, "srst_pre_irq");
        for (int i = 0; i < 10; i++) rd(CMD, 3'd0, v);
        check("srst_pre_data", v, 16'h0009);
        wr(CTL, 3'd6, 16'h0004);
        rdc(CTL, 3'd6, 16'h0080, "srst_status");
        tick(30);
        rdc(CTL, 3'd6, 16'h0080, "srst_hold_status");
        wr(CTL, 3'd6, 16'h0000);
        tick(30);
        chk_irq(1'b0, "srst_no_irq");
        rdc(CMD, 3'd7, 16'h0050, "srst_done_status");
        rdc(CMD, 3'd2, 16'h0001, "srst_seccount");
        rdc(CMD, 3'd3, 16'h0001, "srst_lba0");
        rdc(CMD, 3'd4, 16'h0000, "srst_lba1");
        rdc(CMD, 3'd1, 16'h0001, "srst_error");
        rdc(CMD, 3'd0, 16'h0000, "srst_data");

        // Other device selected: bus never driven, commands ignored
        wr(CMD, 3'd6, 16'h0010);
        rdc(CMD, 3'd7, 16'hFFFF, "nomatch_status_undriven");
        rdc(CMD, 3'd2, 16'hFFFF, "nomatch_seccount_undriven");
        wr(CMD, 3'd7, 16'h0020);
        tick(30);
        chk_irq(1'b0, "nomatch_cmd_ignored");
        wr(CMD, 3'd6, 16'h0000);
        rdc(CMD, 3'd7, 16'h0050, "rematch_status");
        rdc(CMD, 3'd6, 16'h0000, "rematch_device");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
